// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: data widths,
// default reset vector and the layout of one buffered fetch entry.
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, inst} pairs between the memory
// response path and IF_ID; flush empties it and overrides any push/pop.
module fetch_fifo #(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [63:0]   wdata,
   output logic [63:0]   rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == DEPTH_W);
   assign empty   = (count == '0);
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign rdata   = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the fetch PC, issues credit-limited requests to a
// pipelined instruction memory and hands buffered words to IF_ID.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [XLEN-1:0] imem_resp_data,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_pcadd4,
   input  logic            id_ready,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0]   DEPTH_CREDIT = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] DEPTH_OUT    = CW'(DEPTH);

   logic [XLEN-1:0] req_pc;
   logic [XLEN-1:0] resp_pc;
   logic [XLEN-1:0] redirect_target;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_next;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   live;
   logic [CW-1:0]   fifo_count;
   logic [CW:0]     credit;
   logic            accept;
   logic            resp_live;
   logic            fifo_push;
   logic            fifo_pop;
   logic            fifo_full;
   logic            fifo_empty;
   fetch_entry_t    fifo_wdata;
   fetch_entry_t    head;

   assign redirect_target  = redirect_pc & 32'hFFFF_FFFC;
   assign live             = outstanding - discard;
   assign credit           = {1'b0, fifo_count} + {1'b0, live};

   // Every live request already owns a queue slot, so a live response can
   // always be enqueued; the reset term keeps the request line quiet in reset.
   assign imem_req_valid   = !rst && (credit < DEPTH_CREDIT) && (outstanding < DEPTH_OUT);
   assign imem_req_addr    = req_pc;
   assign accept           = imem_req_valid && imem_req_ready;
   assign outstanding_next = outstanding + CW'(accept) - CW'(imem_resp_valid);

   assign resp_live        = imem_resp_valid && (discard == '0) && !redirect;
   assign fifo_push        = resp_live && !fifo_full;
   assign fifo_pop         = inst_valid && id_ready && !redirect;
   assign fifo_wdata       = '{pc: resp_pc, inst: imem_resp_data};

   // On redirect everything still in flight at the end of this cycle is stale,
   // including any request accepted in the same cycle to the old PC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_pc      <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         outstanding <= outstanding_next;
         if (redirect) begin
            req_pc  <= redirect_target;
            resp_pc <= redirect_target;
            discard <= outstanding_next;
         end else begin
            if (accept)    req_pc  <= req_pc + 32'd4;
            if (fifo_push) resp_pc <= resp_pc + 32'd4;
            if (imem_resp_valid && (discard != '0)) discard <= discard - CW'(1);
         end
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (redirect),
      .wdata (fifo_wdata),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Head fields are forced to zero while the queue is empty.
   assign inst_valid  = !fifo_empty;
   assign inst        = inst_valid ? head.inst : '0;
   assign inst_pc     = inst_valid ? head.pc : '0;
   assign inst_pcadd4 = inst_valid ? (head.pc + 32'd4) : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a pipelined memory model answers requests,
// expected PCs/addresses go into queues and a negedge monitor scores them.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [31:0] inst_pcadd4;
   logic        id_ready = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;
   int accepts = 0;
   int pops = 0;
   int first_accept_cycle = -1;
   int first_pop_cycle = -1;
   int mem_lat = 1;
   bit req_check_on = 1'b0;

   logic [31:0] exp_pc [$];
   logic [31:0] exp_req [$];

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_pcadd4     (inst_pcadd4),
      .id_ready        (id_ready),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], INST_NOP[15:0]};
   endfunction

   // Memory model: fixed-latency in-order pipeline, cleared by the shared reset.
   logic [3:0]  pipe_v;
   logic [31:0] pipe_a [4];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_v <= '0;
      end else begin
         for (int i = 3; i > 0; i--) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
         end
         pipe_v[0] <= imem_req_valid && imem_req_ready;
         pipe_a[0] <= imem_req_addr;
      end
   end
   assign imem_resp_valid = pipe_v[mem_lat-1];
   assign imem_resp_data  = mem_word(pipe_a[mem_lat-1]);

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: scores every accepted request and every IF_ID handshake.
   always @(negedge clk) begin
      if (rst) begin
         accepts = 0;
         pops = 0;
         first_accept_cycle = -1;
         first_pop_cycle = -1;
         exp_pc.delete();
         exp_req.delete();
      end else begin
         if (imem_req_valid && imem_req_ready) begin
            accepts++;
            if (first_accept_cycle < 0) first_accept_cycle = cycle;
            if (req_check_on) begin
               if (exp_req.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("[TB] FAIL req_unexpected: got addr 0x%08h, expected no request", imem_req_addr);
               end else begin
                  checkOutput("req_addr", imem_req_addr, exp_req.pop_front());
               end
            end
         end
         if (inst_valid && id_ready && !redirect) begin
            pops++;
            if (first_pop_cycle < 0) first_pop_cycle = cycle;
            if (exp_pc.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL inst_unexpected: got pc 0x%08h, expected no instruction", inst_pc);
            end else begin
               logic [31:0] e;
               e = exp_pc.pop_front();
               checkOutput("inst_pc", inst_pc, e);
               checkOutput("inst", inst, mem_word(e));
               checkOutput("inst_pcadd4", inst_pcadd4, e + 32'd4);
            end
         end
      end
   end

   task automatic applyStimulus(input logic rdy, input logic idr, input logic redir, input logic [31:0] rpc);
      imem_req_ready = rdy;
      id_ready       = idr;
      redirect       = redir;
      redirect_pc    = rpc;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Asserts reset immediately, checks outputs cleared, releases 1 ns after
   // the following edge so that the bench's cycle 0 begins there.
   task automatic doReset(input int lat);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      req_check_on = 1'b0;
      #1;
      checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      checkOutput("rst_req_addr", imem_req_addr, 32'h0);
      checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
      checkOutput("rst_inst", inst, 32'h0);
      checkOutput("rst_inst_pc", inst_pc, 32'h0);
      checkOutput("rst_inst_pcadd4", inst_pcadd4, 32'h0);
      mem_lat = lat;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic pushSeq(input logic [31:0] base, input int n, input bit to_req);
      for (int i = 0; i < n; i++) begin
         if (to_req) exp_req.push_back(base + 32'(4 * i));
         else        exp_pc.push_back(base + 32'(4 * i));
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Streaming with 1-cycle memory.
      $display("[TB] test 1: streaming");
      doReset(1);
      pushSeq(32'h0, 16, 1'b1);
      pushSeq(32'h0, 16, 1'b0);
      req_check_on = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step(12);
      checkOutput("t1_latency", 32'(first_pop_cycle - first_accept_cycle), 32'd2);
      checkOutput("t1_accepts", 32'(accepts), 32'd12);
      checkOutput("t1_pops", 32'(pops), 32'd10);

      // Stall from the start: credits cap requests at DEPTH.
      $display("[TB] test 2: stall and release");
      doReset(1);
      pushSeq(32'h0, 16, 1'b1);
      pushSeq(32'h0, 16, 1'b0);
      req_check_on = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      step(10);
      checkOutput("t2_accepts_stalled", 32'(accepts), 32'd4);
      checkOutput("t2_req_valid_low", {31'b0, imem_req_valid}, 32'h0);
      checkOutput("t2_inst_valid", {31'b0, inst_valid}, 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step(7);
      checkOutput("t2_accepts_after", 32'(accepts), 32'd10);
      checkOutput("t2_pops_after", 32'(pops), 32'd7);

      // 3-cycle memory, two requests in flight, redirect with dirty low bits.
      $display("[TB] test 3: redirect with responses in flight");
      doReset(3);
      pushSeq(32'h100, 16, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step(2);
      checkOutput("t3_inflight", 32'(accepts), 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0103);
      step(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step(12);
      checkOutput("t3_pops_seen", 32'(pops >= 2), 32'd1);

      // Redirect coinciding with a response, a pop and a request accept.
      $display("[TB] test 4: redirect collision");
      doReset(1);
      exp_pc.push_back(32'h0);
      pushSeq(32'h400, 16, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step(3);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h400);
      #2;
      checkOutput("t4_coincide", {29'b0, imem_resp_valid, inst_valid, imem_req_valid}, 32'h7);
      step(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("t4_queue_empty", {31'b0, inst_valid}, 32'h0);
      step(10);
      checkOutput("t4_pops", 32'(pops), 32'd9);

      // Back-to-back redirects: the last target wins.
      $display("[TB] test 5: back-to-back redirects");
      doReset(1);
      exp_pc.push_back(32'h0);
      pushSeq(32'h300, 16, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step(3);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
      step(1);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
      step(1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step(10);
      checkOutput("t5_pops", 32'(pops), 32'd9);

      // Asynchronous reset with a non-empty queue and requests outstanding.
      $display("[TB] test 6: reset mid-operation");
      doReset(3);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      step(4);
      checkOutput("t6_pre_valid", {31'b0, inst_valid}, 32'h1);
      checkOutput("t6_pre_accepts", 32'(accepts), 32'd4);
      #2;
      doReset(3);
      pushSeq(32'h0, 16, 1'b1);
      pushSeq(32'h0, 16, 1'b0);
      req_check_on = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      step(10);
      checkOutput("t6_restart_pops", 32'(pops >= 2), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
